// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ requesters.
// Grants one requester per bounded burst and throttles on full/almost_full.
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned BURST_MAX  = 4
) (
    input  logic                          wr_clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic                          full,
    input  logic                          almost_full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          wr_enb,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          busy,
    output logic [15:0]                   wr_count
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BEAT_W = 4;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t                r_state, w_nxt_state;
    logic [NUM_REQ-1:0]    r_gnt, w_nxt_gnt;
    logic [IDX_W-1:0]      r_gidx, w_nxt_gidx;
    logic [IDX_W-1:0]      r_ptr, w_nxt_ptr;
    logic [BEAT_W-1:0]     r_beat, w_nxt_beat;
    logic                  r_wr_enb, w_nxt_wr_enb;
    logic [DATA_WIDTH-1:0] r_wr_data, w_nxt_wr_data;
    logic                  r_busy;
    logic [CNT_W-1:0]      r_wr_count;
    logic [IDX_W-1:0]      w_sel;
    logic                  w_ok;
    logic                  w_ack_g;
    logic [DATA_WIDTH-1:0] w_words [NUM_REQ];

    // First requester set in r, searching upward from ptr+1 with wrap
    function automatic logic [IDX_W-1:0] rr_pick(input logic [IDX_W-1:0] ptr,
                                                 input logic [NUM_REQ-1:0] r);
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] idx;
        logic             found;
        sel   = ptr;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
        assign w_words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_gnt     = r_gnt;
        w_nxt_gidx    = r_gidx;
        w_nxt_ptr     = r_ptr;
        w_nxt_beat    = r_beat;
        w_nxt_wr_enb  = 1'b0;
        w_nxt_wr_data = r_wr_data;
        ack           = '0;
        w_ack_g       = 1'b0;
        w_sel         = rr_pick(r_ptr, req);
        // Second term covers the write still sitting in the output register
        w_ok          = !full && !(almost_full && r_wr_enb);
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_nxt_state = S_BURST;
                    w_nxt_gnt   = NUM_REQ'(1) << w_sel;
                    w_nxt_gidx  = w_sel;
                    w_nxt_beat  = '0;
                end
            end
            S_BURST: begin
                w_ack_g     = req[r_gidx] && w_ok;
                ack[r_gidx] = w_ack_g;
                if (w_ack_g) begin
                    w_nxt_wr_enb  = 1'b1;
                    w_nxt_wr_data = w_words[r_gidx];
                    w_nxt_beat    = r_beat + BEAT_W'(1);
                end
                if (!req[r_gidx] ||
                    (w_ack_g && (req_last[r_gidx] || r_beat == BEAT_W'(BURST_MAX - 1)))) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_gnt   = '0;
                    w_nxt_ptr   = r_gidx;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_gidx    <= '0;
            r_ptr     <= IDX_W'(NUM_REQ - 1);
            r_beat    <= '0;
            r_wr_enb  <= 1'b0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_gnt     <= w_nxt_gnt;
            r_gidx    <= w_nxt_gidx;
            r_ptr     <= w_nxt_ptr;
            r_beat    <= w_nxt_beat;
            r_wr_enb  <= w_nxt_wr_enb;
            r_wr_data <= w_nxt_wr_data;
            r_busy    <= (w_nxt_state == S_BURST);
        end
    end

    // Saturating count of words handed to the FIFO
    always_ff @(posedge wr_clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_count <= '0;
        end else if (r_wr_enb && r_wr_count != {CNT_W{1'b1}}) begin
            r_wr_count <= r_wr_count + CNT_W'(1);
        end
    end

    assign gnt      = r_gnt;
    assign wr_enb   = r_wr_enb;
    assign wr_data  = r_wr_data;
    assign busy     = r_busy;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: queued requester agents, a FIFO
// occupancy model for back-pressure, and a monitor popping expected writes/grants.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } word_t;

    logic           wr_clk = 1'b0;
    logic           rstn   = 1'b0;
    logic [NR-1:0]  req, req_last, gnt, ack;
    logic [NR*DW-1:0] req_data;
    logic           full, almost_full, wr_enb, busy, rd;
    logic [DW-1:0]  wr_data;
    logic [15:0]    wr_count;

    logic [NR-1:0]    s_req, s_last, s_gnt, s_ack;
    logic [NR*DW-1:0] s_data;
    logic             s_wr_enb, s_busy;
    logic [DW-1:0]    s_wr_data;
    logic [15:0]      s_wr_count;

    word_t         src_q [NR][$];
    logic [DW-1:0] exp_q[$];
    int            exp_gnt_q[$];
    int            exp_len_q[$];

    int  n_tests = 0, n_fail = 0;
    int  occ = 3, cyc = 0, bp_wr = 0;
    bit  bp_en = 1'b0, saw_full = 1'b0;
    logic [NR-1:0] prev_gnt = '0;
    int  acks = 0, gap = 0;
    bit  gap_valid = 1'b0;

    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_MAX(4)) dut (
        .wr_clk(wr_clk), .rstn(rstn), .req(req), .req_data(req_data),
        .req_last(req_last), .full(full), .almost_full(almost_full),
        .gnt(gnt), .ack(ack), .wr_enb(wr_enb), .wr_data(wr_data),
        .busy(busy), .wr_count(wr_count));

    // Long bursts keep the saturation run short
    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_MAX(15)) dut_sat (
        .wr_clk(wr_clk), .rstn(rstn), .req(s_req), .req_data(s_data),
        .req_last(s_last), .full(1'b0), .almost_full(1'b0),
        .gnt(s_gnt), .ack(s_ack), .wr_enb(s_wr_enb), .wr_data(s_wr_data),
        .busy(s_busy), .wr_count(s_wr_count));

    // Depth-8 FIFO occupancy model, drained one entry every 4 cycles
    always @(posedge wr_clk) begin
        cyc <= cyc + 1;
        if (!bp_en) occ <= 3;
        else        occ <= occ + (wr_enb ? 1 : 0) - (rd ? 1 : 0);
    end
    assign rd          = bp_en && (cyc % 4 == 0) && (occ > 0);
    assign full        = bp_en && (occ >= 8);
    assign almost_full = bp_en && (occ >= 7);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic load(input int i, input logic [DW-1:0] base, input int n, input bit last);
        for (int j = 0; j < n; j++) begin
            word_t w;
            w.d    = base + DW'(j);
            w.last = last && (j == n - 1);
            src_q[i].push_back(w);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] base, input int n);
        for (int j = 0; j < n; j++) exp_q.push_back(base + DW'(j));
    endtask

    task automatic push_gnt(input int g, input int len);
        exp_gnt_q.push_back(g);
        exp_len_q.push_back(len);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || exp_gnt_q.size() != 0 || exp_len_q.size() != 0 ||
                gnt != '0) && k < 400) begin
            @(negedge wr_clk);
            #4;
            k++;
        end
        chk({name, "_complete"}, 32'(k < 400), 32'd1);
        repeat (2) @(negedge wr_clk);
    endtask

    // Requester agents: present queue head, retire it when ack seen before the edge
    initial begin
        req = '0; req_last = '0; req_data = '0;
        forever begin
            @(negedge wr_clk);
            for (int i = 0; i < NR; i++) begin
                if (src_q[i].size() > 0) begin
                    req[i]               = 1'b1;
                    req_data[i*DW +: DW] = src_q[i][0].d;
                    req_last[i]          = src_q[i][0].last;
                end else begin
                    req[i]      = 1'b0;
                    req_last[i] = 1'b0;
                end
            end
            #4;
            for (int i = 0; i < NR; i++)
                if (ack[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
    end

    // Monitor: writes, grant order, burst lengths, idle gaps, ack rules
    initial begin
        forever begin
            @(negedge wr_clk);
            #3;
            if (!rstn) begin
                prev_gnt  = '0;
                acks      = 0;
                gap_valid = 1'b0;
            end else begin
                if (wr_enb) begin
                    chk("write_pending", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) chk("wr_data", 32'(wr_data), 32'(exp_q.pop_front()));
                    if (bp_en) begin
                        bp_wr++;
                        chk("no_write_while_full", 32'(full), 32'd0);
                    end
                end
                if (bp_en && full) saw_full = 1'b1;
                if (gnt != '0 && prev_gnt == '0) begin
                    chk("gnt_pending", 32'(exp_gnt_q.size() != 0), 32'd1);
                    if (exp_gnt_q.size() != 0) chk("gnt", 32'(gnt), 32'd1 << exp_gnt_q.pop_front());
                    chk("busy_in_burst", 32'(busy), 32'd1);
                    if (gap_valid) chk("idle_gap", 32'(gap), 32'd1);
                    acks = 0;
                end
                if (gnt == '0 && prev_gnt != '0) begin
                    chk("len_pending", 32'(exp_len_q.size() != 0), 32'd1);
                    if (exp_len_q.size() != 0) chk("burst_len", 32'(acks), 32'(exp_len_q.pop_front()));
                    gap       = 0;
                    gap_valid = 1'b1;
                end
                if (gnt == '0) begin
                    gap++;
                    if (req == '0) gap_valid = 1'b0;
                end
                if (ack != '0) begin
                    chk("ack_within_gnt", 32'((ack & ~gnt) == '0), 32'd1);
                    acks++;
                end
                if (bp_en && gnt != '0)
                    chk("ack_backpressure", 32'(|ack),
                        32'((|(req & gnt)) && !full && !(almost_full && wr_enb)));
                prev_gnt = gnt;
            end
        end
    end

    initial begin
        int n_w;
        bit d1, d2;
        s_req = '0; s_last = '0; s_data = '0;
        repeat (3) @(posedge wr_clk);
        @(negedge wr_clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_wr_enb", 32'(wr_enb), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        @(posedge wr_clk); #2; rstn = 1'b1;

        // Single requester, three words, last on the third
        load(0, 8'h01, 3, 1'b1);
        push_exp(8'h01, 3); push_gnt(0, 3);
        wait_idle("single");
        chk("single_wr_count", 32'(wr_count), 32'd3);

        // Requester 1 withdraws after one word; requester 3 waits
        @(posedge wr_clk); #2;
        load(1, 8'h10, 1, 1'b0);
        load(3, 8'h30, 2, 1'b1);
        push_exp(8'h10, 1); push_exp(8'h30, 2);
        push_gnt(1, 1); push_gnt(3, 2);
        wait_idle("withdraw");

        // All four continuously requesting, bursts capped at 4
        @(posedge wr_clk); #2;
        load(0, 8'h40, 8, 1'b0);
        load(1, 8'h50, 4, 1'b0);
        load(2, 8'h60, 4, 1'b0);
        load(3, 8'h70, 4, 1'b0);
        push_exp(8'h40, 4); push_exp(8'h50, 4); push_exp(8'h60, 4);
        push_exp(8'h70, 4); push_exp(8'h44, 4);
        for (int g = 0; g < 5; g++) push_gnt(g % NR, 4);
        wait_idle("round_robin");
        chk("rr_wr_count", 32'(wr_count), 32'd26);

        // Back-pressure from a depth-8 FIFO preloaded with 3 entries
        @(posedge wr_clk); #2;
        bp_en = 1'b1; bp_wr = 0; saw_full = 1'b0;
        load(2, 8'h80, 8, 1'b1);
        push_exp(8'h80, 8); push_gnt(2, 4); push_gnt(2, 4);
        wait_idle("backpressure");
        chk("bp_write_pulses", 32'(bp_wr), 32'd8);
        chk("bp_reached_full", 32'(saw_full), 32'd1);
        @(posedge wr_clk); #2; bp_en = 1'b0;

        // Asynchronous reset while a write is in flight
        @(posedge wr_clk); #2;
        load(1, 8'h90, 4, 1'b0);
        push_exp(8'h90, 4); push_gnt(1, 4);
        begin
            int k;
            k = 0;
            do begin
                @(posedge wr_clk); #2;
                k++;
            end while (!wr_enb && k < 50);
            chk("mid_burst_write_seen", 32'(wr_enb), 32'd1);
        end
        rstn = 1'b0;
        #1;
        chk("arst_wr_enb", 32'(wr_enb), 32'd0);
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_wr_count", 32'(wr_count), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < NR; i++) src_q[i].delete();
        exp_q.delete(); exp_gnt_q.delete(); exp_len_q.delete();
        repeat (2) @(posedge wr_clk);
        #2; rstn = 1'b1;
        for (int i = 0; i < NR; i++) load(i, DW'(8'hA0 + 16 * i), 2, 1'b1);
        for (int i = 0; i < NR; i++) begin
            push_exp(DW'(8'hA0 + 16 * i), 2);
            push_gnt(i, 2);
        end
        wait_idle("post_reset");
        chk("post_reset_wr_count", 32'(wr_count), 32'd8);

        // Saturation: one requester streaming bursts of 15
        s_req = 4'b0001; s_data = {NR*DW{1'b0}} | 32'h5A;
        n_w = 0; d1 = 1'b0; d2 = 1'b0;
        for (int c = 0; c < 72000 && n_w < 65540; c++) begin
            @(negedge wr_clk);
            if (n_w == 65534 && !d1) begin
                chk("sat_fffe", 32'(s_wr_count), 32'hFFFE);
                d1 = 1'b1;
            end
            if (n_w == 65535 && !d2) begin
                chk("sat_ffff", 32'(s_wr_count), 32'hFFFF);
                d2 = 1'b1;
            end
            if (s_wr_enb) n_w++;
        end
        chk("sat_writes_done", 32'(n_w >= 65540), 32'd1);
        s_req = '0;
        repeat (5) @(negedge wr_clk);
        chk("sat_hold", 32'(s_wr_count), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
